// File: rtl/elem_packer_if.sv
// Stream bundle between an element source, the packer and a wide-word consumer.
// slave is the packer side; master is the side that drives elements and accepts words.
interface elem_packer_if #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 4
);
  localparam int CNT_W = $clog2(NUM_ELEM + 1);

  logic [ELEM_WIDTH-1:0]          elem_in_i;
  logic                           elem_in_last_i;
  logic                           elem_in_valid_i;
  logic                           elem_in_ready_o;
  logic [NUM_ELEM*ELEM_WIDTH-1:0] pack_out_o;
  logic [CNT_W-1:0]               pack_out_count_o;
  logic                           pack_out_last_o;
  logic                           pack_out_valid_o;
  logic                           pack_out_ready_i;

  modport slave (
    input  elem_in_i, elem_in_last_i, elem_in_valid_i, pack_out_ready_i,
    output elem_in_ready_o, pack_out_o, pack_out_count_o, pack_out_last_o, pack_out_valid_o
  );

  modport master (
    output elem_in_i, elem_in_last_i, elem_in_valid_i, pack_out_ready_i,
    input  elem_in_ready_o, pack_out_o, pack_out_count_o, pack_out_last_o, pack_out_valid_o
  );
endinterface

// File: rtl/elem_packer.sv
// Packs NUM_ELEM consecutive elements into one wide word; a last flag closes a short word.
// Word valid the cycle after its final element; input ready is forwarded from output ready while a word is held.
module elem_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 4
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  elem_packer_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_ELEM + 1);
  localparam int IDX_W  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int WORD_W = NUM_ELEM * ELEM_WIDTH;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_ELEM);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (NUM_ELEM < 1) begin : g_bad_num_elem
      $fatal(1, "elem_packer: NUM_ELEM must be >= 1");
    end
  endgenerate

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              last_q, last_d;

  logic              hsi, hso;
  logic [IDX_W-1:0]  slot;
  logic [CNT_W-1:0]  cnt_inc;

  assign bus.pack_out_o       = buf_q;
  assign bus.pack_out_count_o = cnt_q;
  assign bus.pack_out_last_o  = last_q;
  assign bus.pack_out_valid_o = (state_q == HOLD);
  // While a word is held, a slot frees up only if the consumer takes the word this cycle.
  assign bus.elem_in_ready_o  = (state_q == FILL) ? 1'b1 : bus.pack_out_ready_i;

  assign hsi     = bus.elem_in_valid_i & bus.elem_in_ready_o;
  assign hso     = bus.pack_out_valid_o & bus.pack_out_ready_i;
  assign slot    = (NUM_ELEM == 1) ? '0 : cnt_q[IDX_W-1:0];
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (hsi) begin
          for (int k = 0; k < NUM_ELEM; k++) begin
            if (slot == IDX_W'(k)) begin
              buf_d[k*ELEM_WIDTH +: ELEM_WIDTH] = bus.elem_in_i;
            end
          end
          cnt_d  = cnt_inc;
          last_d = bus.elem_in_last_i;
          if (cnt_inc == CNT_FULL || bus.elem_in_last_i) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hso) begin
          buf_d = '0;
          if (hsi) begin
            // The element arriving alongside the drain starts the next word at slot 0.
            buf_d[ELEM_WIDTH-1:0] = bus.elem_in_i;
            cnt_d   = CNT_ONE;
            last_d  = bus.elem_in_last_i;
            state_d = (NUM_ELEM == 1 || bus.elem_in_last_i) ? HOLD : FILL;
          end else begin
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_elem_packer.sv
// Directed bench for elem_packer with NUM_ELEM=4 and NUM_ELEM=1 instances and a reference-model scoreboard.
module tb_elem_packer;
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  elem_packer_if #(.ELEM_WIDTH(8), .NUM_ELEM(4)) b4 ();
  elem_packer_if #(.ELEM_WIDTH(8), .NUM_ELEM(1)) b1 ();

  elem_packer #(.ELEM_WIDTH(8), .NUM_ELEM(4)) u_dut4 (.clk_i(clk), .arst_ni(arst_n), .bus(b4));
  elem_packer #(.ELEM_WIDTH(8), .NUM_ELEM(1)) u_dut1 (.clk_i(clk), .arst_ni(arst_n), .bus(b1));

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  c;
    logic        l;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  logic [31:0] acc = '0;
  int   acc_n = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference packer: builds expected words from accepted elements; drained words are compared in order.
  always @(negedge clk) begin
    if (!arst_n) begin
      acc   = '0;
      acc_n = 0;
    end else begin
      if (b4.elem_in_valid_i && b4.elem_in_ready_o) begin
        acc[acc_n*8 +: 8] = b4.elem_in_i;
        acc_n++;
        if (acc_n == 4 || b4.elem_in_last_i) begin
          e4.d = acc;
          e4.c = 3'(acc_n);
          e4.l = b4.elem_in_last_i;
          q4.push_back(e4);
          acc   = '0;
          acc_n = 0;
        end
      end
      if (b4.pack_out_valid_o && b4.pack_out_ready_i) begin
        chk("w4_expected_pending", 64'(q4.size() > 0), 64'(1));
        if (q4.size() > 0) begin
          e4 = q4.pop_front();
          chk("w4_data",  64'(b4.pack_out_o),       64'(e4.d));
          chk("w4_count", 64'(b4.pack_out_count_o), 64'(e4.c));
          chk("w4_last",  64'(b4.pack_out_last_o),  64'(e4.l));
        end
      end
      if (b1.elem_in_valid_i && b1.elem_in_ready_o) begin
        e1.d = 32'(b1.elem_in_i);
        e1.c = 3'd1;
        e1.l = b1.elem_in_last_i;
        q1.push_back(e1);
      end
      if (b1.pack_out_valid_o && b1.pack_out_ready_i) begin
        chk("w1_expected_pending", 64'(q1.size() > 0), 64'(1));
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("w1_data",  64'(b1.pack_out_o),       64'(e1.d));
          chk("w1_count", 64'(b1.pack_out_count_o), 64'(e1.c));
          chk("w1_last",  64'(b1.pack_out_last_o),  64'(e1.l));
        end
      end
    end
  end

  // Presents one element on the 4-wide instance and returns one posedge+1 after it is accepted.
  task automatic send(input logic [7:0] d, input logic l, output int waits);
    int n = 0;
    b4.elem_in_i       = d;
    b4.elem_in_last_i  = l;
    b4.elem_in_valid_i = 1'b1;
    @(negedge clk);
    while (!b4.elem_in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
    waits = n;
    @(posedge clk);
    #1;
    b4.elem_in_valid_i = 1'b0;
    b4.elem_in_last_i  = 1'b0;
  endtask

  initial begin
    int w;
    arst_n = 1'b0;
    b4.elem_in_i = '0; b4.elem_in_last_i = 1'b0; b4.elem_in_valid_i = 1'b0; b4.pack_out_ready_i = 1'b1;
    b1.elem_in_i = '0; b1.elem_in_last_i = 1'b0; b1.elem_in_valid_i = 1'b0; b1.pack_out_ready_i = 1'b1;

    // Reset with random input activity
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b4.elem_in_i = 8'($urandom); b4.elem_in_last_i = 1'($urandom);
      b4.elem_in_valid_i = 1'($urandom); b4.pack_out_ready_i = 1'($urandom);
      b1.elem_in_i = 8'($urandom); b1.elem_in_last_i = 1'($urandom);
      b1.elem_in_valid_i = 1'($urandom); b1.pack_out_ready_i = 1'($urandom);
      @(negedge clk);
      chk("rst_valid", 64'(b4.pack_out_valid_o), 64'(0));
      chk("rst_count", 64'(b4.pack_out_count_o), 64'(0));
      chk("rst_data",  64'(b4.pack_out_o),       64'(0));
      chk("rst_last",  64'(b4.pack_out_last_o),  64'(0));
      chk("rst_ready", 64'(b4.elem_in_ready_o),  64'(1));
      chk("rst1_valid", 64'(b1.pack_out_valid_o), 64'(0));
      chk("rst1_ready", 64'(b1.elem_in_ready_o),  64'(1));
    end
    @(posedge clk); #1;
    b4.elem_in_valid_i = 1'b0; b4.elem_in_last_i = 1'b0; b4.pack_out_ready_i = 1'b1;
    b1.elem_in_valid_i = 1'b0; b1.elem_in_last_i = 1'b0; b1.pack_out_ready_i = 1'b1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Full word, one-cycle valid pulse
    send(8'h11, 1'b0, w); send(8'h22, 1'b0, w); send(8'h33, 1'b0, w); send(8'h44, 1'b0, w);
    @(negedge clk);
    chk("t2_valid", 64'(b4.pack_out_valid_o), 64'(1));
    chk("t2_data",  64'(b4.pack_out_o),       64'h44332211);
    chk("t2_count", 64'(b4.pack_out_count_o), 64'(4));
    chk("t2_last",  64'(b4.pack_out_last_o),  64'(0));
    @(negedge clk);
    chk("t2_valid_drop", 64'(b4.pack_out_valid_o), 64'(0));
    @(posedge clk); #1;

    // Short word closed by last
    send(8'hAA, 1'b0, w); send(8'hBB, 1'b1, w);
    @(negedge clk);
    chk("t3_valid", 64'(b4.pack_out_valid_o), 64'(1));
    chk("t3_data",  64'(b4.pack_out_o),       64'h0000BBAA);
    chk("t3_count", 64'(b4.pack_out_count_o), 64'(2));
    chk("t3_last",  64'(b4.pack_out_last_o),  64'(1));
    @(posedge clk); #1;

    // Output stall for 5 cycles with the next element waiting
    b4.pack_out_ready_i = 1'b0;
    send(8'h01, 1'b0, w); send(8'h02, 1'b0, w); send(8'h03, 1'b0, w); send(8'h04, 1'b0, w);
    b4.elem_in_i = 8'h55; b4.elem_in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(b4.pack_out_valid_o), 64'(1));
      chk("t4_hold_data",  64'(b4.pack_out_o),       64'h04030201);
      chk("t4_hold_rdy",   64'(b4.elem_in_ready_o),  64'(0));
      @(posedge clk);
    end
    #1;
    b4.pack_out_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_release_rdy", 64'(b4.elem_in_ready_o), 64'(1));
    @(posedge clk); #1;
    b4.elem_in_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_slot0", 64'(b4.pack_out_o[7:0]), 64'h55);
    chk("t4_cnt1",  64'(b4.pack_out_count_o), 64'(1));
    @(posedge clk); #1;
    send(8'h66, 1'b0, w); send(8'h77, 1'b0, w); send(8'h88, 1'b0, w);

    // Sustained stream, no input stalls
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, w);
      chk("t5_no_stall", 64'(w), 64'(0));
    end
    @(posedge clk); #1;

    // Partial word dropped by reset
    send(8'hE1, 1'b0, w); send(8'hE2, 1'b0, w);
    arst_n = 1'b0;
    #3;
    chk("t6_rst_count", 64'(b4.pack_out_count_o), 64'(0));
    chk("t6_rst_data",  64'(b4.pack_out_o),       64'(0));
    @(posedge clk); #1;
    arst_n = 1'b1;
    send(8'h01, 1'b0, w); send(8'h02, 1'b0, w); send(8'h03, 1'b0, w); send(8'h04, 1'b0, w);
    @(negedge clk);
    chk("t6_data",  64'(b4.pack_out_o),       64'h04030201);
    chk("t6_count", 64'(b4.pack_out_count_o), 64'(4));
    @(posedge clk); #1;

    // Single-element words, back to back
    for (int i = 0; i < 6; i++) begin
      b1.elem_in_i       = 8'(8'hA0 + i);
      b1.elem_in_last_i  = (i == 3);
      b1.elem_in_valid_i = 1'b1;
      @(negedge clk);
      chk("t6n1_rdy", 64'(b1.elem_in_ready_o), 64'(1));
      if (i > 0) chk("t6n1_valid", 64'(b1.pack_out_valid_o), 64'(1));
      @(posedge clk); #1;
    end
    b1.elem_in_valid_i = 1'b0;
    b1.elem_in_last_i  = 1'b0;
    @(negedge clk);
    chk("t6n1_tail_valid", 64'(b1.pack_out_valid_o), 64'(1));
    @(negedge clk);
    chk("t6n1_idle_valid", 64'(b1.pack_out_valid_o), 64'(0));

    repeat (4) @(negedge clk);
    chk("q4_drained", 64'(q4.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("acc_empty",  64'(acc_n),     64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
